icap_pr_controller: RTL and testbench

Sequences partial-reconfiguration bitstream writes into the ICAPE3 wrapper (`icap_inst`). It accepts a length-tagged stream of 32-bit bitstream words from the upstream DMA/FIFO through a valid/ready handshake. It drives the ICAP `CSIB`/`RDWRB`/`I` pins, stalling on `AVAIL`, then waits for `PRDONE`/`PRERROR` and reports status to the host register block. It sits directly between the bitstream FIFO and `icap_inst`, in the `CLK` domain.

---
 rtl/icap_ctrl_pkg.sv | 9 +
 rtl/icap_bit_swap.sv | 11 +
 rtl/icap_pr_controller.sv | 92 +++++++++
 tb/tb_icap_pr_controller.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icap_ctrl_pkg.sv
// icap_ctrl_pkg: shared FSM state type, err_code values and the bitstream sync word
package icap_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, WAIT_DONE, FINISH} state_t;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_PRERROR = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_ABORT = 2'd3;
  localparam logic [31:0] SYNC_WORD = 32'hAA995566;
endpackage

// File: rtl/icap_bit_swap.sv
// icap_bit_swap: optional per-byte bit reversal of a 32-bit word (din in, dout out, BIT_SWAP=0 passes through)
module icap_bit_swap #(
  parameter bit BIT_SWAP = 1
) (
  input  logic [31:0] din,
  output logic [31:0] dout
);
  for (genvar i = 0; i < 32; i++) begin : g_bit
    assign dout[i] = BIT_SWAP ? din[i ^ 7] : din[i];
  end
endmodule

// File: rtl/icap_pr_controller.sv
// icap_pr_controller: streams len words from s_valid/s_ready/s_data into ICAP csib/rdwrb/i (stalls on avail), then waits prdone/prerror/timeout and reports busy/done/err_code/words_sent
module icap_pr_controller #(
  parameter bit BIT_SWAP = 1,
  parameter int LEN_W = 24,
  parameter int DONE_TIMEOUT = 65535
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             s_valid,
  input  logic [31:0]      s_data,
  output logic             s_ready,
  output logic             icap_csib,
  output logic             icap_rdwrb,
  output logic [31:0]      icap_i,
  input  logic             icap_avail,
  input  logic             icap_prdone,
  input  logic             icap_prerror,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err_code,
  output logic [LEN_W-1:0] words_sent
);
  import icap_ctrl_pkg::*;
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  state_t state, state_n;
  logic [LEN_W-1:0] remaining;
  logic [TW-1:0] tcnt;
  logic [1:0] err_n;
  logic [31:0] swapped;
  logic perr, hs;
  icap_bit_swap #(.BIT_SWAP(BIT_SWAP)) u_swap (.din(s_data), .dout(swapped));
  assign s_ready = state == STREAM && icap_avail && remaining != '0 && !abort;
  assign hs = s_valid && s_ready;
  assign busy = state != IDLE;
  assign done = state == FINISH;
  always_comb begin
    state_n = state;
    err_n = err_code;
    case (state)
      IDLE: if (start) begin
        state_n = len == '0 ? FINISH : STREAM;
        err_n = ERR_NONE;
      end
      STREAM: if (abort) begin
        state_n = FINISH;
        err_n = ERR_ABORT;
      end else if (hs && remaining == LEN_W'(1)) state_n = WAIT_DONE;
      WAIT_DONE: begin
        state_n = FINISH;
        err_n = abort ? ERR_ABORT :
                (icap_prerror || perr) ? ERR_PRERROR :
                icap_prdone ? ERR_NONE :
                tcnt == TW'(DONE_TIMEOUT - 1) ? ERR_TIMEOUT : err_code;
        if (!abort && !icap_prerror && !perr && !icap_prdone && tcnt != TW'(DONE_TIMEOUT - 1)) state_n = WAIT_DONE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state <= IDLE;
      icap_csib <= 1'b1;
      icap_rdwrb <= 1'b0;
      icap_i <= '0;
      err_code <= ERR_NONE;
      words_sent <= '0;
      remaining <= '0;
      tcnt <= '0;
      perr <= 1'b0;
    end else begin
      state <= state_n;
      err_code <= err_n;
      icap_csib <= !hs;
      icap_rdwrb <= 1'b0;
      tcnt <= state == WAIT_DONE ? tcnt + 1'b1 : '0;
      if (hs) icap_i <= swapped;
      if (state == STREAM && icap_prerror) perr <= 1'b1;
      if (state == IDLE && start) begin
        remaining <= len;
        words_sent <= '0;
        perr <= 1'b0;
      end
      if (hs) begin
        remaining <= remaining - 1'b1;
        words_sent <= words_sent + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_icap_pr_controller.sv
// tb_icap_pr_controller: directed self-checking bench for icap_pr_controller
module tb_icap_pr_controller;
  localparam int LEN_W = 24;
  localparam int TMO = 20;
  logic CLK = 1'b0;
  logic RSTN;
  logic start, abort, s_valid, icap_avail, icap_prdone, icap_prerror;
  logic [LEN_W-1:0] len;
  logic [31:0] s_data;
  logic s_ready, icap_csib, icap_rdwrb, busy, done;
  logic [31:0] icap_i;
  logic [1:0] err_code;
  logic [LEN_W-1:0] words_sent;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [31:0] cap[$];
  int cap_cyc[$];
  logic [31:0] words[16];
  icap_pr_controller #(.BIT_SWAP(1), .LEN_W(LEN_W), .DONE_TIMEOUT(TMO)) dut (
    .CLK(CLK), .RSTN(RSTN), .start(start), .len(len), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .icap_csib(icap_csib), .icap_rdwrb(icap_rdwrb), .icap_i(icap_i),
    .icap_avail(icap_avail), .icap_prdone(icap_prdone), .icap_prerror(icap_prerror),
    .busy(busy), .done(done), .err_code(err_code), .words_sent(words_sent)
  );
  always #5 CLK = ~CLK;
  always @(negedge CLK) begin
    cyc <= cyc + 1;
    if (icap_csib === 1'b0) begin
      cap.push_back(icap_i);
      cap_cyc.push_back(cyc);
    end
  end
  function automatic logic [31:0] swap_ref(input logic [31:0] d);
    logic [31:0] r;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 8; j++) r[8*k+j] = d[8*k+7-j];
    return r;
  endfunction
  task automatic launch(input int n);
    @(negedge CLK);
    start = 1'b1;
    len = LEN_W'(n);
    @(negedge CLK);
    start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin $display("FAIL launch_busy: got %b want 1", busy); fails++; end
  endtask
  task automatic feed(input int n, input int gap_after, input int gap_len, input int perr_at);
    int idx = 0;
    int g = 0;
    for (int c = 0; c < 200 && idx < n; c++) begin
      @(negedge CLK);
      icap_avail = !(idx == gap_after && g < gap_len);
      icap_prerror = idx == perr_at;
      s_valid = 1'b1;
      s_data = words[idx];
      if (!icap_avail) g++;
      #1;
      if (!icap_avail) begin
        tests++;
        if (s_ready !== 1'b0) begin $display("FAIL gap_ready: got %b want 0", s_ready); fails++; end
        if (g > 1) begin
          tests++;
          if (icap_csib !== 1'b1) begin $display("FAIL gap_csib: got %b want 1", icap_csib); fails++; end
        end
      end
      if (s_ready) idx++;
    end
    tests++;
    if (idx != n) begin $display("FAIL feed_budget: accepted %0d want %0d", idx, n); fails++; end
  endtask
  task automatic src_idle();
    @(negedge CLK);
    s_valid = 1'b0;
    icap_avail = 1'b1;
    icap_prerror = 1'b0;
  endtask
  task automatic test_reset();
    RSTN = 1'b0; start = 0; len = 0; abort = 0; s_valid = 0; s_data = 0;
    icap_avail = 1; icap_prdone = 0; icap_prerror = 0;
    repeat (3) @(negedge CLK);
    tests++;
    if ({icap_csib, icap_rdwrb, icap_i, s_ready, busy, done, err_code, words_sent} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 24'd0}) begin
      $display("FAIL reset_vals: csib=%b rdwrb=%b i=%h rdy=%b busy=%b done=%b err=%0d ws=%0d", icap_csib, icap_rdwrb, icap_i, s_ready, busy, done, err_code, words_sent);
      fails++;
    end
    RSTN = 1'b1;
  endtask
  task automatic test_basic();
    int b = cap.size();
    logic [31:0] exp[4] = '{32'hFFFFFFFF, 32'h000000DD, 32'h88440022, 32'h5599AA66};
    words[0] = 32'hFFFFFFFF; words[1] = 32'h000000BB; words[2] = 32'h11220044; words[3] = 32'hAA995566;
    launch(4);
    feed(4, -1, 0, -1);
    src_idle();
    icap_prdone = 1'b1;
    @(negedge CLK);
    icap_prdone = 1'b0;
    tests++;
    if (cap.size() - b != 4) begin $display("FAIL basic_count: got %0d want 4", cap.size() - b); fails++; end
    else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (cap[b+i] !== exp[i]) begin $display("FAIL basic_word%0d: got %h want %h", i, cap[b+i], exp[i]); fails++; end
      end
      tests++;
      if (cap_cyc[b+3] - cap_cyc[b] != 3) begin $display("FAIL basic_consec: span %0d want 3", cap_cyc[b+3] - cap_cyc[b]); fails++; end
    end
    tests++;
    if ({done, err_code, words_sent} !== {1'b1, 2'd0, 24'd4}) begin $display("FAIL basic_done: done=%b err=%0d ws=%0d want 1 0 4", done, err_code, words_sent); fails++; end
    @(negedge CLK);
    tests++;
    if ({done, busy} !== 2'b00) begin $display("FAIL basic_idle: done=%b busy=%b want 0 0", done, busy); fails++; end
  endtask
  task automatic test_avail_gap();
    int b = cap.size();
    for (int i = 0; i < 8; i++) words[i] = 32'h01234567 + 32'h11111111 * i;
    launch(8);
    feed(8, 2, 3, -1);
    src_idle();
    icap_prdone = 1'b1;
    @(negedge CLK);
    icap_prdone = 1'b0;
    tests++;
    if (cap.size() - b != 8) begin $display("FAIL gap_count: got %0d want 8", cap.size() - b); fails++; end
    else for (int i = 0; i < 8; i++) begin
      tests++;
      if (cap[b+i] !== swap_ref(words[i])) begin $display("FAIL gap_word%0d: got %h want %h", i, cap[b+i], swap_ref(words[i])); fails++; end
    end
    tests++;
    if ({done, err_code, words_sent} !== {1'b1, 2'd0, 24'd8}) begin $display("FAIL gap_done: done=%b err=%0d ws=%0d", done, err_code, words_sent); fails++; end
  endtask
  task automatic test_timeout();
    int k = 0;
    words[0] = 32'h80000001; words[1] = 32'h00FF00FF;
    launch(2);
    feed(2, -1, 0, -1);
    src_idle();
    while (done !== 1'b1 && k < 100) begin
      @(negedge CLK);
      k++;
    end
    tests++;
    if (k != TMO) begin $display("FAIL timeout_cycles: got %0d want %0d", k, TMO); fails++; end
    tests++;
    if (err_code !== 2'd2) begin $display("FAIL timeout_err: got %0d want 2", err_code); fails++; end
  endtask
  task automatic test_prerror();
    int b = cap.size();
    for (int i = 0; i < 5; i++) words[i] = 32'hC0DE0000 + i;
    launch(5);
    feed(5, -1, 0, 2);
    src_idle();
    @(negedge CLK);
    tests++;
    if (cap.size() - b != 5) begin $display("FAIL perr_count: got %0d want 5", cap.size() - b); fails++; end
    tests++;
    if ({done, err_code, words_sent} !== {1'b1, 2'd1, 24'd5}) begin $display("FAIL perr_done: done=%b err=%0d ws=%0d want 1 1 5", done, err_code, words_sent); fails++; end
  endtask
  task automatic test_abort();
    int b = cap.size();
    for (int i = 0; i < 10; i++) words[i] = 32'h5A000000 + i;
    launch(10);
    feed(2, -1, 0, -1);
    @(negedge CLK);
    s_valid = 1'b1;
    s_data = words[2];
    abort = 1'b1;
    #1;
    tests++;
    if (s_ready !== 1'b0) begin $display("FAIL abort_ready: got %b want 0", s_ready); fails++; end
    @(negedge CLK);
    abort = 1'b0;
    s_valid = 1'b0;
    tests++;
    if ({icap_csib, done, err_code, words_sent} !== {1'b1, 1'b1, 2'd3, 24'd2}) begin
      $display("FAIL abort_done: csib=%b done=%b err=%0d ws=%0d want 1 1 3 2", icap_csib, done, err_code, words_sent);
      fails++;
    end
    @(negedge CLK);
    tests++;
    if (cap.size() - b != 2) begin $display("FAIL abort_count: got %0d want 2", cap.size() - b); fails++; end
  endtask
  task automatic test_priority();
    words[0] = 32'h12345678;
    launch(1);
    feed(1, -1, 0, -1);
    src_idle();
    icap_prdone = 1'b1;
    icap_prerror = 1'b1;
    @(negedge CLK);
    icap_prdone = 1'b0;
    icap_prerror = 1'b0;
    tests++;
    if ({done, err_code} !== {1'b1, 2'd1}) begin $display("FAIL prio_perr: done=%b err=%0d want 1 1", done, err_code); fails++; end
    launch(1);
    feed(1, -1, 0, -1);
    src_idle();
    icap_prdone = 1'b1;
    abort = 1'b1;
    @(negedge CLK);
    icap_prdone = 1'b0;
    abort = 1'b0;
    tests++;
    if ({done, err_code} !== {1'b1, 2'd3}) begin $display("FAIL prio_abort: done=%b err=%0d want 1 3", done, err_code); fails++; end
  endtask
  task automatic test_len_zero();
    int b = cap.size();
    int d = 0;
    launch(0);
    tests++;
    if ({done, err_code} !== {1'b1, 2'd0}) begin $display("FAIL len0_done: done=%b err=%0d want 1 0", done, err_code); fails++; end
    d += int'(done);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      d += int'(done);
    end
    tests++;
    if (d != 1 || busy !== 1'b0) begin $display("FAIL len0_pulse: pulses=%0d busy=%b want 1 0", d, busy); fails++; end
    tests++;
    if (cap.size() != b) begin $display("FAIL len0_csib: writes=%0d want 0", cap.size() - b); fails++; end
  endtask
  task automatic test_reset_mid();
    int b = cap.size();
    for (int i = 0; i < 4; i++) words[i] = 32'hDEAD0000 + i;
    launch(4);
    feed(2, -1, 0, -1);
    @(negedge CLK);
    s_data = words[2];
    RSTN = 1'b0;
    @(negedge CLK);
    tests++;
    if ({icap_csib, icap_rdwrb, icap_i, s_ready, busy, done, err_code, words_sent} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 24'd0}) begin
      $display("FAIL rstmid_vals: csib=%b rdwrb=%b i=%h rdy=%b busy=%b done=%b err=%0d ws=%0d", icap_csib, icap_rdwrb, icap_i, s_ready, busy, done, err_code, words_sent);
      fails++;
    end
    RSTN = 1'b1;
    s_valid = 1'b0;
    repeat (2) @(negedge CLK);
    tests++;
    if (cap.size() - b != 2) begin $display("FAIL rstmid_count: got %0d want 2", cap.size() - b); fails++; end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_avail_gap();
    test_timeout();
    test_prerror();
    test_abort();
    test_priority();
    test_len_zero();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
